// File: rtl/magnitude_sequencer.sv
// magnitude_sequencer: streams one FFT frame from bin RAM through the magnitude
// approximator into the magnitude buffer, with watchdog and sticky error flags.
module magnitude_sequencer #(
    parameter int DATA_WIDTH = 24,
    parameter int NUM_BINS   = 512,
    parameter int ADDR_WIDTH = 9,
    parameter int WD_LIMIT   = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_frame_ready,
    output logic                    o_rd_en,
    output logic [ADDR_WIDTH-1:0]   o_rd_addr,
    input  logic [2*DATA_WIDTH-1:0] i_rd_data,
    output logic                    o_mag_start,
    output logic [2*DATA_WIDTH-1:0] o_mag_complex,
    input  logic [DATA_WIDTH-1:0]   i_mag_magnitude,
    input  logic                    i_mag_valid,
    output logic                    o_wr_en,
    output logic [ADDR_WIDTH-1:0]   o_wr_addr,
    output logic [DATA_WIDTH-1:0]   o_wr_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_overrun,
    output logic                    o_error
);
    localparam int WDW = $clog2(WD_LIMIT + 1);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(NUM_BINS - 1);
    localparam logic [WDW-1:0] WD_LAST = WDW'(WD_LIMIT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_cnt;
    logic [WDW-1:0]        wd;
    logic                  active;

    // Results are only accepted while a frame is in flight; anything else is a stray.
    assign active        = state == ISSUE || state == DRAIN;
    assign o_wr_en       = i_mag_valid && active;
    assign o_wr_addr     = wr_cnt;
    assign o_wr_data     = o_wr_en ? i_mag_magnitude : '0;
    assign o_mag_complex = i_rd_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            wd          <= '0;
            o_rd_en     <= 1'b0;
            o_rd_addr   <= '0;
            o_mag_start <= 1'b0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_overrun   <= 1'b0;
            o_error     <= 1'b0;
        end else begin
            o_done      <= 1'b0;
            o_mag_start <= o_rd_en;
            if (o_wr_en)
                wr_cnt <= (wr_cnt == LAST) ? '0 : wr_cnt + ADDR_WIDTH'(1);
            if (i_frame_ready && state != IDLE)
                o_overrun <= 1'b1;
            if (i_mag_valid && !active)
                o_error <= 1'b1;
            case (state)
                IDLE: if (i_frame_ready) begin
                    state     <= ISSUE;
                    o_busy    <= 1'b1;
                    o_rd_en   <= 1'b1;
                    o_rd_addr <= '0;
                    wr_cnt    <= '0;
                    wd        <= '0;
                end
                ISSUE: if (o_rd_addr == LAST) begin
                    state     <= DRAIN;
                    o_rd_en   <= 1'b0;
                    o_rd_addr <= '0;
                end else begin
                    o_rd_addr <= o_rd_addr + ADDR_WIDTH'(1);
                end
                DRAIN: if (o_wr_en && wr_cnt == LAST) begin
                    state  <= DONE;
                    o_done <= 1'b1;
                end else if (i_mag_valid) begin
                    wd <= '0;
                end else if (wd == WD_LAST) begin
                    state   <= DONE;
                    o_done  <= 1'b1;
                    o_error <= 1'b1;
                end else begin
                    wd <= wd + WDW'(1);
                end
                DONE: begin
                    state  <= IDLE;
                    o_busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/magnitude_sequencer.md
MAGNITUDE_SEQUENCER -- requirements
Module: magnitude_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, the width of one real/imag component and of one magnitude.
REQ-002 SHALL have parameter NUM_BINS, default 512, the number of FFT bins processed per frame (power of two, 2..4096).
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, equal to log2(NUM_BINS).
REQ-004 SHALL have parameter WD_LIMIT, default 16, the drain watchdog limit in cycles.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port i_frame_ready, input, 1 bit: one-cycle pulse meaning a complete FFT frame is in bin RAM.
REQ-008 SHALL have port o_rd_en, output, 1 bit: bin RAM read enable.
REQ-009 SHALL have port o_rd_addr, output, ADDR_WIDTH bits: bin RAM read address.
REQ-010 SHALL have port i_rd_data, input, 2*DATA_WIDTH bits: {real, imag}, valid exactly 1 cycle after o_rd_en.
REQ-011 SHALL have port o_mag_start, output, 1 bit: start strobe to magnitude_approximator.
REQ-012 SHALL have port o_mag_complex, output, 2*DATA_WIDTH bits: operand to magnitude_approximator.
REQ-013 SHALL have port i_mag_magnitude, input, DATA_WIDTH bits: result from magnitude_approximator.
REQ-014 SHALL have port i_mag_valid, input, 1 bit: result valid from magnitude_approximator.
REQ-015 SHALL have port o_wr_en, output, 1 bit: magnitude buffer write enable.
REQ-016 SHALL have port o_wr_addr, output, ADDR_WIDTH bits: magnitude buffer write address.
REQ-017 SHALL have port o_wr_data, output, DATA_WIDTH bits: magnitude buffer write data.
REQ-018 SHALL have port o_busy, output, 1 bit: high in every state except IDLE.
REQ-019 SHALL have port o_done, output, 1 bit: one-cycle end-of-frame pulse.
REQ-020 SHALL have port o_overrun, output, 1 bit: sticky flag, i_frame_ready received while busy.
REQ-021 SHALL have port o_error, output, 1 bit: sticky flag, watchdog expiry or unexpected i_mag_valid.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE, DRAIN and DONE.
REQ-023 SHALL move from IDLE to ISSUE on i_frame_ready, clearing the read counter, write counter and watchdog.
REQ-024 SHALL, in ISSUE, assert o_rd_en every cycle with o_rd_addr = 0,1,...,NUM_BINS-1 consecutively, one bin per cycle.
REQ-025 SHALL move from ISSUE to DRAIN in the cycle after the read of address NUM_BINS-1 is issued.
REQ-026 SHALL assert o_mag_start exactly one cycle after each o_rd_en, registered, with o_mag_complex = i_rd_data passed combinationally in that cycle.
REQ-027 SHALL, on each i_mag_valid, assert o_wr_en in the same cycle with o_wr_data = i_mag_magnitude and o_wr_addr = write counter, then increment the write counter.
REQ-028 SHALL accept results at one per cycle, because magnitude_approximator has no backpressure and writes are never stalled.
REQ-029 SHALL move from DRAIN to DONE in the cycle after the write of address NUM_BINS-1.
REQ-030 SHALL, in DRAIN, increment the watchdog on cycles without i_mag_valid and clear it on i_mag_valid.
REQ-031 SHALL, when the watchdog reaches WD_LIMIT, set o_error and go to DONE.
REQ-032 SHALL, in DONE, pulse o_done for 1 cycle and return to IDLE.
REQ-033 SHALL ignore i_frame_ready in ISSUE, DRAIN or DONE and set o_overrun.
REQ-034 SHALL leave o_overrun and o_error set until reset.
REQ-035 SHALL, on i_mag_valid in IDLE, set o_error and suppress o_wr_en.
REQ-036 SHALL ignore i_frame_ready and i_mag_valid arriving in the same IDLE cycle except for REQ-035, and still start the frame.
REQ-037 SHALL wrap counters only through the NUM_BINS terminal compare, so no address ever exceeds NUM_BINS-1.

Reset
REQ-038 SHALL, while reset is low, force the state to IDLE, all counters to 0, and all outputs (o_rd_en, o_rd_addr, o_mag_start, o_wr_en, o_wr_addr, o_wr_data, o_busy, o_done, o_overrun, o_error) to 0; o_mag_complex is exempt because it follows i_rd_data.
REQ-039 SHALL abort any frame on reset assertion mid-frame, with no further reads or writes after release until a new i_frame_ready.

Verification (NUM_BINS=8, approximator model latency 3, bin k = {k+1, 0})
REQ-040 SHALL verify a single frame: i_frame_ready pulse -> reads at addresses 0..7 on 8 consecutive cycles, writes at addresses 0..7 with data 1..8, o_done exactly once, 8+1+3+1 cycles after the pulse.
REQ-041 SHALL verify overrun: i_frame_ready repeated during ISSUE -> o_overrun=1, and exactly 8 reads and 8 writes occur.
REQ-042 SHALL verify the watchdog: model drops result 5 -> 7 writes, o_error=1 after 16 idle cycles, o_done pulses, state returns to IDLE.
REQ-043 SHALL verify a stray result: i_mag_valid while IDLE -> o_error=1 and o_wr_en stays 0.
REQ-044 SHALL verify reset mid-frame: reset low after read 3 -> all outputs 0; after release no activity until a new frame, which then completes normally.
REQ-045 SHALL verify back-to-back frames: i_frame_ready the cycle after o_done -> second frame completes with addresses starting at 0 and o_overrun=0.
